firebird7_in_gate2_tessent_ssn_pipe_ctrl: RTL and testbench

Sequencer for the SSN bus input pipeline stages of firebird7_in_gate2. It receives configuration over a valid/ready handshake and holds the pipeline stages in synchronous reset until a run is requested. It then releases the stages one at a time from input to output, flags when pipe-output data is valid, and frames the stream into packets of a configured length. At stop it drains cleanly at a packet boundary and re-flushes the stages.

---
 rtl/firebird7_in_gate2_tessent_ssn_pipe_ctrl.sv | 171 +++++++++++++++++
 tb/tb_firebird7_in_gate2_tessent_ssn_pipe_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/firebird7_in_gate2_tessent_ssn_pipe_ctrl.sv
// Sequencer for the SSN bus input pipeline of firebird7_in_gate2.
// Holds the pipeline stages in flush until a run is configured. It then
// releases the stages input-first and frames the pipe output into packets.
// On stop it finishes the current packet and flushes the stages again.
module firebird7_in_gate2_tessent_ssn_pipe_ctrl #(
  parameter int PIPE_DEPTH = 2,
  parameter int PKT_W      = 16
) (
  input  logic                  bus_clock,
  input  logic                  bus_sync_reset,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic                  cfg_enable,
  input  logic [PKT_W-1:0]      cfg_packet_size,
  output logic [PIPE_DEPTH-1:0] stage_flush,
  output logic                  bus_valid,
  output logic                  pkt_start,
  output logic                  pkt_end,
  output logic [7:0]            pkt_count,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_FILL,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [3:0]            r_fill, w_fill_nxt;
  logic [PKT_W-1:0]      r_beat, w_beat_nxt;
  logic [PKT_W-1:0]      r_size, w_size_nxt;
  logic [PKT_W-1:0]      r_pend_size, w_pend_size_nxt;
  logic                  r_pend_vld, w_pend_vld_nxt;
  logic                  r_stop_pend, w_stop_pend_nxt;
  logic [7:0]            r_pkt_count, w_pkt_count_nxt;
  logic [PIPE_DEPTH-1:0] r_stage_flush, w_flush_nxt;
  logic                  r_bus_valid, r_pkt_start, r_pkt_end, r_busy;
  logic                  w_bus_valid_nxt, w_pkt_start_nxt, w_pkt_end_nxt, w_busy_nxt;
  logic                  w_accept, w_acc_run, w_acc_stop, w_last_beat;

  // Configuration is only taken while idle or streaming.
  assign cfg_ready   = (r_state == S_IDLE) || (r_state == S_RUN);
  assign w_accept    = cfg_valid && cfg_ready;
  assign w_acc_run   = w_accept && cfg_enable && (cfg_packet_size != '0);
  assign w_acc_stop  = w_accept && !cfg_enable;
  assign w_last_beat = (r_beat == (r_size - PKT_W'(1)));

  assign stage_flush = r_stage_flush;
  assign bus_valid   = r_bus_valid;
  assign pkt_start   = r_pkt_start;
  assign pkt_end     = r_pkt_end;
  assign pkt_count   = r_pkt_count;
  assign busy        = r_busy;

  // Next-state, counters and pending-configuration bookkeeping.
  always_comb begin
    w_state_nxt     = r_state;
    w_fill_nxt      = r_fill;
    w_beat_nxt      = r_beat;
    w_size_nxt      = r_size;
    w_pend_size_nxt = r_pend_size;
    w_pend_vld_nxt  = r_pend_vld;
    w_stop_pend_nxt = r_stop_pend;
    w_pkt_count_nxt = r_pkt_count;
    case (r_state)
      S_IDLE: begin
        w_pend_vld_nxt  = 1'b0;
        w_stop_pend_nxt = 1'b0;
        if (w_acc_run) begin
          w_size_nxt  = cfg_packet_size;
          w_state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: begin
        w_fill_nxt  = 4'd0;
        w_state_nxt = S_FILL;
      end
      S_FILL: begin
        if (r_fill == 4'(PIPE_DEPTH - 1)) begin
          w_beat_nxt  = '0;
          w_state_nxt = S_RUN;
        end else begin
          w_fill_nxt = r_fill + 4'd1;
        end
      end
      S_RUN: begin
        // An accept on the last beat still counts toward the boundary below.
        if (w_acc_run) begin
          w_pend_size_nxt = cfg_packet_size;
          w_pend_vld_nxt  = 1'b1;
        end
        if (w_acc_stop) begin
          w_stop_pend_nxt = 1'b1;
        end
        if (w_last_beat) begin
          w_pkt_count_nxt = r_pkt_count + 8'd1;
          w_beat_nxt      = '0;
          if (w_stop_pend_nxt) begin
            w_state_nxt     = S_DRAIN;
            w_pend_vld_nxt  = 1'b0;
            w_stop_pend_nxt = 1'b0;
          end else if (w_pend_vld_nxt) begin
            w_size_nxt     = w_pend_size_nxt;
            w_pend_vld_nxt = 1'b0;
          end
        end else begin
          w_beat_nxt = r_beat + PKT_W'(1);
        end
      end
      S_DRAIN: begin
        w_pend_vld_nxt  = 1'b0;
        w_stop_pend_nxt = 1'b0;
        w_state_nxt     = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state so every output is registered.
  always_comb begin
    w_flush_nxt = '1;
    if (w_state_nxt == S_FILL) begin
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        w_flush_nxt[i] = (4'(i) > w_fill_nxt);
      end
    end else if (w_state_nxt == S_RUN) begin
      w_flush_nxt = '0;
    end
    w_bus_valid_nxt = (w_state_nxt == S_RUN);
    w_pkt_start_nxt = w_bus_valid_nxt && (w_beat_nxt == '0);
    w_pkt_end_nxt   = w_bus_valid_nxt && (w_beat_nxt == (w_size_nxt - PKT_W'(1)));
    w_busy_nxt      = (w_state_nxt != S_IDLE);
  end

  // Control state and registered outputs; reset returns to a flushed idle pipe.
  always_ff @(posedge bus_clock) begin
    if (bus_sync_reset) begin
      r_state       <= S_IDLE;
      r_pend_vld    <= 1'b0;
      r_stop_pend   <= 1'b0;
      r_pkt_count   <= 8'd0;
      r_stage_flush <= '1;
      r_bus_valid   <= 1'b0;
      r_pkt_start   <= 1'b0;
      r_pkt_end     <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pend_vld    <= w_pend_vld_nxt;
      r_stop_pend   <= w_stop_pend_nxt;
      r_pkt_count   <= w_pkt_count_nxt;
      r_stage_flush <= w_flush_nxt;
      r_bus_valid   <= w_bus_valid_nxt;
      r_pkt_start   <= w_pkt_start_nxt;
      r_pkt_end     <= w_pkt_end_nxt;
      r_busy        <= w_busy_nxt;
    end
  end

  // Counters and sizes; always reloaded before use, so no reset needed.
  always_ff @(posedge bus_clock) begin
    r_fill      <= w_fill_nxt;
    r_beat      <= w_beat_nxt;
    r_size      <= w_size_nxt;
    r_pend_size <= w_pend_size_nxt;
  end

endmodule

// File: tb/tb_firebird7_in_gate2_tessent_ssn_pipe_ctrl.sv
// Bench for the SSN pipe sequencer: directed stimulus, expected stream beats
// queued ahead of time and popped by a monitor on every valid output cycle.
module tb_firebird7_in_gate2_tessent_ssn_pipe_ctrl;

  logic        bus_clock;
  logic        bus_sync_reset;
  logic        cfg_valid;
  logic        cfg_ready;
  logic        cfg_enable;
  logic [15:0] cfg_packet_size;
  logic [1:0]  stage_flush;
  logic        bus_valid;
  logic        pkt_start;
  logic        pkt_end;
  logic [7:0]  pkt_count;
  logic        busy;

  firebird7_in_gate2_tessent_ssn_pipe_ctrl #(
    .PIPE_DEPTH(2),
    .PKT_W(16)
  ) dut (
    .bus_clock(bus_clock),
    .bus_sync_reset(bus_sync_reset),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_enable(cfg_enable),
    .cfg_packet_size(cfg_packet_size),
    .stage_flush(stage_flush),
    .bus_valid(bus_valid),
    .pkt_start(pkt_start),
    .pkt_end(pkt_end),
    .pkt_count(pkt_count),
    .busy(busy)
  );

  typedef struct packed {
    logic       s;
    logic       e;
    logic [7:0] c;
  } beat_t;

  beat_t      exp_q[$];
  logic [7:0] exp_cnt;
  int         total;
  int         bad;

  initial begin
    bus_clock = 1'b0;
    forever #5 bus_clock = ~bus_clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge bus_clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic cfg(input logic en, input int sz);
    cfg_valid       = 1'b1;
    cfg_enable      = en;
    cfg_packet_size = 16'(sz);
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic exp_packets(input int size, input int n);
    beat_t t;
    for (int p = 0; p < n; p++) begin
      for (int b = 0; b < size; b++) begin
        t.s = (b == 0);
        t.e = (b == size - 1);
        t.c = exp_cnt;
        exp_q.push_back(t);
      end
      exp_cnt = exp_cnt + 8'd1;
    end
  endtask

  task automatic exp_beat(input logic s, input logic e);
    beat_t t;
    t.s = s;
    t.e = e;
    t.c = exp_cnt;
    exp_q.push_back(t);
  endtask

  // Monitor: every valid output cycle must match the next queued beat.
  always @(negedge bus_clock) begin
    beat_t t;
    if (bus_valid === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL beat_unexpected: got s=%0b e=%0b cnt=%0d want no valid beat",
                 pkt_start, pkt_end, pkt_count);
      end else begin
        t = exp_q.pop_front();
        if ({pkt_start, pkt_end, pkt_count} !== {t.s, t.e, t.c}) begin
          bad++;
          $display("FAIL beat: got s=%0b e=%0b cnt=%0d want s=%0b e=%0b cnt=%0d",
                   pkt_start, pkt_end, pkt_count, t.s, t.e, t.c);
        end
      end
    end
  end

  initial begin
    total           = 0;
    bad             = 0;
    exp_cnt         = 8'd0;
    bus_sync_reset  = 1'b1;
    cfg_valid       = 1'b0;
    cfg_enable      = 1'b0;
    cfg_packet_size = 16'd0;

    // Reset state.
    tick();
    chk("rst_cfg_ready", 32'(cfg_ready), 1);
    tick();
    chk("rst_flush", 32'(stage_flush), 3);
    chk("rst_valid", 32'(bus_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_count", 32'(pkt_count), 0);
    bus_sync_reset = 1'b0;
    tick();

    // Run size 4, three packets, stop mid third packet.
    exp_packets(4, 3);
    cfg(1'b1, 4);
    chk("e0_flush", 32'(stage_flush), 3);
    chk("e0_busy", 32'(busy), 1);
    chk("e0_ready", 32'(cfg_ready), 0);
    tick();
    chk("e1_flush", 32'(stage_flush), 2);
    tick();
    chk("e2_flush", 32'(stage_flush), 0);
    chk("e2_valid", 32'(bus_valid), 0);
    tick();
    chk("e3_valid", 32'(bus_valid), 1);
    chk("e3_start", 32'(pkt_start), 1);
    ticks(9);
    cfg(1'b0, 4);
    ticks(2);
    chk("drain_valid", 32'(bus_valid), 0);
    chk("drain_flush", 32'(stage_flush), 3);
    chk("drain_ready", 32'(cfg_ready), 0);
    chk("drain_count", 32'(pkt_count), 32'(exp_cnt));
    tick();
    chk("idle_busy", 32'(busy), 0);
    chk("idle_ready", 32'(cfg_ready), 1);

    // Size 1 for 300 packets: count wraps and ends at 44.
    bus_sync_reset = 1'b1;
    tick();
    chk("rst2_count", 32'(pkt_count), 0);
    bus_sync_reset = 1'b0;
    exp_cnt = 8'd0;
    exp_packets(1, 300);
    cfg(1'b1, 1);
    ticks(3);
    ticks(299);
    cfg(1'b0, 1);
    chk("wrap_count", 32'(pkt_count), 44);
    chk("wrap_valid", 32'(bus_valid), 0);
    tick();

    // Mid-run size updates, with a later update overriding an earlier one.
    exp_packets(4, 1);
    exp_packets(2, 1);
    exp_packets(5, 1);
    cfg(1'b1, 4);
    ticks(3);
    tick();
    cfg(1'b1, 2);
    ticks(2);
    cfg(1'b1, 3);
    cfg(1'b1, 5);
    tick();
    cfg(1'b0, 7);
    ticks(3);
    chk("upd_drain_busy", 32'(busy), 1);
    chk("upd_drain_count", 32'(pkt_count), 32'(exp_cnt));
    tick();

    // Graceful stop at beat 2 of a 5-beat packet.
    exp_packets(5, 1);
    cfg(1'b1, 5);
    ticks(3);
    ticks(2);
    cfg(1'b0, 5);
    tick();
    chk("stop_last_end", 32'(pkt_end), 1);
    tick();
    chk("stop_drain_valid", 32'(bus_valid), 0);
    chk("stop_drain_busy", 32'(busy), 1);
    tick();
    chk("stop_idle_busy", 32'(busy), 0);
    chk("stop_idle_ready", 32'(cfg_ready), 1);

    // Stop landing on the pkt_end cycle ends on that packet.
    exp_packets(3, 2);
    cfg(1'b1, 3);
    ticks(3);
    ticks(5);
    cfg(1'b0, 3);
    chk("stop_on_end_valid", 32'(bus_valid), 0);
    chk("stop_on_end_count", 32'(pkt_count), 32'(exp_cnt));
    tick();

    // Illegal and disabled configs in idle are consumed without effect.
    cfg(1'b1, 0);
    chk("size0_busy", 32'(busy), 0);
    chk("size0_flush", 32'(stage_flush), 3);
    tick();
    chk("size0_busy2", 32'(busy), 0);
    cfg(1'b0, 4);
    chk("dis_busy", 32'(busy), 0);

    // cfg_valid held through FLUSH/FILL is only taken once RUN is entered.
    exp_packets(2, 1);
    exp_packets(3, 1);
    cfg_valid       = 1'b1;
    cfg_enable      = 1'b1;
    cfg_packet_size = 16'd2;
    tick();
    cfg_packet_size = 16'd3;
    chk("hold_flush_ready", 32'(cfg_ready), 0);
    tick();
    chk("hold_fill0_ready", 32'(cfg_ready), 0);
    tick();
    chk("hold_fill1_ready", 32'(cfg_ready), 0);
    tick();
    chk("hold_run_ready", 32'(cfg_ready), 1);
    tick();
    cfg_valid = 1'b0;
    tick();
    cfg(1'b0, 3);
    ticks(2);
    chk("hold_drain_valid", 32'(bus_valid), 0);
    tick();

    // Reset during FILL.
    cfg(1'b1, 4);
    tick();
    bus_sync_reset = 1'b1;
    tick();
    chk("rstfill_flush", 32'(stage_flush), 3);
    chk("rstfill_busy", 32'(busy), 0);
    chk("rstfill_count", 32'(pkt_count), 0);
    chk("rstfill_ready", 32'(cfg_ready), 1);
    bus_sync_reset = 1'b0;
    exp_cnt = 8'd0;

    // Reset mid-packet with a pending size; partial packet is not counted.
    exp_beat(1'b1, 1'b0);
    exp_beat(1'b0, 1'b0);
    cfg(1'b1, 4);
    ticks(3);
    cfg(1'b1, 2);
    bus_sync_reset = 1'b1;
    tick();
    chk("rstrun_valid", 32'(bus_valid), 0);
    chk("rstrun_flush", 32'(stage_flush), 3);
    chk("rstrun_count", 32'(pkt_count), 0);
    chk("rstrun_busy", 32'(busy), 0);
    bus_sync_reset = 1'b0;

    // Fresh run after reset uses only the new size.
    exp_packets(3, 2);
    cfg(1'b1, 3);
    ticks(3);
    ticks(5);
    cfg(1'b0, 3);
    chk("post_rst_count", 32'(pkt_count), 2);
    ticks(3);

    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
